// File: rtl/id_hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/bubble controller:
// FSM state encoding, control-bundle field positions and the bubble value.
package id_hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int NB_CTRL_DEF = 22;

  // Field positions inside the packed control bundle (HALT travels separately).
  localparam int CTRL_REGDST     = 0;
  localparam int CTRL_ALUSRC     = 1;
  localparam int CTRL_MEMTOREG   = 2;
  localparam int CTRL_REGWRITE   = 3;
  localparam int CTRL_MEMREAD    = 4;
  localparam int CTRL_MEMWRITE   = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_BNE        = 7;
  localparam int CTRL_JUMP       = 8;
  localparam int CTRL_ALUOP_LSB  = 9;   // 4 bits: 12..9
  localparam int CTRL_MEMSZ_LSB  = 13;  // 2 bits: 14..13
  localparam int CTRL_MEMSIGNED  = 15;
  localparam int CTRL_SHAMT_SEL  = 16;
  localparam int CTRL_LUI        = 17;
  localparam int CTRL_IMM_ZEXT   = 18;
  localparam int CTRL_LINK       = 19;
  localparam int CTRL_JR         = 20;
  localparam int CTRL_JALR       = 21;

  // All-zero bundle: no register write, no memory access, no redirect.
  localparam logic [NB_CTRL_DEF-1:0] CTRL_DEFAULT = '0;

endpackage

// File: rtl/id_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load currently in EX is about to write.
module id_load_use_detect #(
  parameter int NB_REG = 5
) (
  input  logic              i_EX_MemRead,
  input  logic [NB_REG-1:0] i_EX_Rt,
  input  logic [NB_REG-1:0] i_ID_Rs,
  input  logic [NB_REG-1:0] i_ID_Rt,
  input  logic              i_ID_UsesRt,
  output logic              o_hazard
);

  logic rs_match;
  logic rt_match;

  // $zero is never a real dependency, so loads into r0 never stall.
  assign rs_match = (i_EX_Rt == i_ID_Rs);
  assign rt_match = i_ID_UsesRt && (i_EX_Rt == i_ID_Rt);
  assign o_hazard = i_EX_MemRead && (i_EX_Rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_hazard_bubble_ctrl.sv
// ID-stage hazard controller: load-use stall, flush/halt bubbling, debug freeze.
// Optional cumulative stall counter enabled by `define ID_HAZARD_STALL_CNT_EN.
module id_hazard_bubble_ctrl
  import id_hazard_pkg::*;
#(
  parameter int NB_CTRL  = NB_CTRL_DEF,
  parameter int NB_REG   = 5,
  parameter int LOAD_LAT = 1
`ifdef ID_HAZARD_STALL_CNT_EN
  , parameter int NB_CNT = 16
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Enable,
  input  logic               i_EX_MemRead,
  input  logic [NB_REG-1:0]  i_EX_Rt,
  input  logic [NB_REG-1:0]  i_ID_Rs,
  input  logic [NB_REG-1:0]  i_ID_Rt,
  input  logic               i_ID_UsesRt,
  input  logic               i_Flush,
  input  logic [NB_CTRL-1:0] i_Ctrl,
  input  logic               i_HALT,
  output logic [NB_CTRL-1:0] o_Ctrl,
  output logic               o_HALT,
  output logic               o_PCWrite,
  output logic               o_IF_ID_Write,
  output logic               o_Stall,
  output logic               o_Halted
`ifdef ID_HAZARD_STALL_CNT_EN
  , output logic [NB_CNT-1:0] o_StallCount
`endif
);

  // Remaining-bubble counter only needs to hold LOAD_LAT-1.
  localparam int NB_LAT = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  state_e            state_q, state_d;
  logic [NB_LAT-1:0] cnt_q, cnt_d;

  logic               hazard;
  logic [NB_CTRL-1:0] ctrl;
  logic               halt;
  logic               pc_write;
  logic               stall;

  id_load_use_detect #(
    .NB_REG (NB_REG)
  ) u_detect (
    .i_EX_MemRead (i_EX_MemRead),
    .i_EX_Rt      (i_EX_Rt),
    .i_ID_Rs      (i_ID_Rs),
    .i_ID_Rt      (i_ID_Rt),
    .i_ID_UsesRt  (i_ID_UsesRt),
    .o_hazard     (hazard)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = NB_CTRL'(CTRL_DEFAULT);
    halt     = 1'b0;
    pc_write = 1'b0;
    stall    = 1'b0;

    if (i_Enable) begin
      case (state_q)
        RUN: begin
          if (i_Flush) begin
            pc_write = 1'b1;
          end else if (hazard) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = NB_LAT'(LOAD_LAT - 1);
            end
          end else if (i_HALT) begin
            halt    = 1'b1;
            state_d = HALTED;
          end else begin
            ctrl     = i_Ctrl;
            pc_write = 1'b1;
          end
        end
        STALL: begin
          if (i_Flush) begin
            pc_write = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q - NB_LAT'(1);
            if (cnt_q == NB_LAT'(1)) state_d = RUN;
          end
        end
        HALTED:  ;
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after an edge.
  assign o_Ctrl        = i_reset ? ctrl : '0;
  assign o_HALT        = i_reset && halt;
  assign o_PCWrite     = i_reset && pc_write;
  assign o_IF_ID_Write = i_reset && pc_write;
  assign o_Stall       = i_reset && stall;
  assign o_Halted      = i_reset && (state_q == HALTED);

`ifdef ID_HAZARD_STALL_CNT_EN
  logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_StallCount = i_reset ? stall_cnt_q : '0;
`endif

endmodule

// File: tb/tb_id_hazard_bubble_ctrl.sv
// Directed bench for id_hazard_bubble_ctrl: one LOAD_LAT=1 and one LOAD_LAT=3
// instance share the same stimulus; expectations are hand-computed per instance.
module tb_id_hazard_bubble_ctrl;

  localparam logic [21:0] CTRL_IN = 22'h2AAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, ex_memread, id_uses_rt, flush, halt_in;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic [21:0] ctrl_in;

  logic [21:0] d1_ctrl, d3_ctrl;
  logic        d1_halt, d1_pcw, d1_ifid, d1_stall, d1_halted;
  logic        d3_halt, d3_pcw, d3_ifid, d3_stall, d3_halted;
`ifdef ID_HAZARD_STALL_CNT_EN
  logic [1:0]  d1_scnt;
  logic [15:0] d3_scnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_bubbles;

  always #5 clk = ~clk;

  id_hazard_bubble_ctrl #(
    .NB_CTRL (22), .NB_REG (5), .LOAD_LAT (1)
`ifdef ID_HAZARD_STALL_CNT_EN
    , .NB_CNT (2)
`endif
  ) u_dut1 (
    .i_clk (clk), .i_reset (rst_n), .i_Enable (enable),
    .i_EX_MemRead (ex_memread), .i_EX_Rt (ex_rt), .i_ID_Rs (id_rs), .i_ID_Rt (id_rt),
    .i_ID_UsesRt (id_uses_rt), .i_Flush (flush), .i_Ctrl (ctrl_in), .i_HALT (halt_in),
    .o_Ctrl (d1_ctrl), .o_HALT (d1_halt), .o_PCWrite (d1_pcw), .o_IF_ID_Write (d1_ifid),
    .o_Stall (d1_stall), .o_Halted (d1_halted)
`ifdef ID_HAZARD_STALL_CNT_EN
    , .o_StallCount (d1_scnt)
`endif
  );

  id_hazard_bubble_ctrl #(
    .NB_CTRL (22), .NB_REG (5), .LOAD_LAT (3)
`ifdef ID_HAZARD_STALL_CNT_EN
    , .NB_CNT (16)
`endif
  ) u_dut3 (
    .i_clk (clk), .i_reset (rst_n), .i_Enable (enable),
    .i_EX_MemRead (ex_memread), .i_EX_Rt (ex_rt), .i_ID_Rs (id_rs), .i_ID_Rt (id_rt),
    .i_ID_UsesRt (id_uses_rt), .i_Flush (flush), .i_Ctrl (ctrl_in), .i_HALT (halt_in),
    .o_Ctrl (d3_ctrl), .o_HALT (d3_halt), .o_PCWrite (d3_pcw), .o_IF_ID_Write (d3_ifid),
    .o_Stall (d3_stall), .o_Halted (d3_halted)
`ifdef ID_HAZARD_STALL_CNT_EN
    , .o_StallCount (d3_scnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    enable     = 1'b1;
    ex_memread = 1'b0;
    ex_rt      = '0;
    id_rs      = '0;
    id_rt      = '0;
    id_uses_rt = 1'b0;
    flush      = 1'b0;
    halt_in    = 1'b0;
    ctrl_in    = CTRL_IN;
  endtask

  // Advance to 2 ns after the next rising edge; inputs are then changed and
  // outputs sampled 1 ns later, well away from either clock edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
  endtask

  task automatic exp1(input string tag, input logic [21:0] c, input logic pcw, input logic stl);
    check({tag, "_d1_ctrl"},  32'(d1_ctrl),  32'(c));
    check({tag, "_d1_pcw"},   32'(d1_pcw),   32'(pcw));
    check({tag, "_d1_ifid"},  32'(d1_ifid),  32'(pcw));
    check({tag, "_d1_stall"}, 32'(d1_stall), 32'(stl));
  endtask

  task automatic exp3(input string tag, input logic [21:0] c, input logic pcw, input logic stl);
    check({tag, "_d3_ctrl"},  32'(d3_ctrl),  32'(c));
    check({tag, "_d3_pcw"},   32'(d3_pcw),   32'(pcw));
    check({tag, "_d3_ifid"},  32'(d3_ifid),  32'(pcw));
    check({tag, "_d3_stall"}, 32'(d3_stall), 32'(stl));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    exp3("rst", '0, 1'b0, 1'b0);
    check("rst_d3_halted", 32'(d3_halted), 0);
    check("rst_d3_halt", 32'(d3_halt), 0);
`ifdef ID_HAZARD_STALL_CNT_EN
    check("rst_d3_scnt", 32'(d3_scnt), 0);
`endif
    step();
    rst_n = 1'b1;
    #1;

    // Pass-through with no hazard
    exp1("nohaz", CTRL_IN, 1'b1, 1'b0);
    exp3("nohaz", CTRL_IN, 1'b1, 1'b0);
    check("nohaz_d1_halt", 32'(d1_halt), 0);

    // Load-use on rs: d1 bubbles once, d3 keeps stalling
    step(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    exp1("lu_rs0", '0, 1'b0, 1'b1);
    exp3("lu_rs0", '0, 1'b0, 1'b1);
    step(); ex_memread = 1'b0; #1;
    exp1("lu_rs1", CTRL_IN, 1'b1, 1'b0);
    exp3("lu_rs1", '0, 1'b0, 1'b1);

    // LOAD_LAT=3 on rt: exactly three bubbles
    reset_dut();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    n_bubbles = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin step(); ex_memread = 1'b0; end
      #1;
      if (d3_stall) n_bubbles++;
      exp3($sformatf("lat3_c%0d", c), (c < 3) ? 22'h0 : CTRL_IN, c >= 3, c < 3);
      exp1($sformatf("lat1_c%0d", c), (c < 1) ? 22'h0 : CTRL_IN, c >= 1, c < 1);
    end
    check("lat3_bubbles", 32'(n_bubbles), 3);
`ifdef ID_HAZARD_STALL_CNT_EN
    check("lat3_scnt", 32'(d3_scnt), 3);
    check("lat1_scnt", 32'(d1_scnt), 1);
`endif

    // Load into r0, and rt match without UsesRt: no stall
    step(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
    exp3("rt0", CTRL_IN, 1'b1, 1'b0);
    step(); ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
    exp3("nouse", CTRL_IN, 1'b1, 1'b0);

    // Hazard and flush together: flush wins, no STALL entry
    step(); idle(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; flush = 1'b1; #1;
    exp3("flush_haz", '0, 1'b1, 1'b0);
    exp1("flush_haz", '0, 1'b1, 1'b0);
    step(); idle(); #1;
    exp3("post_flush", CTRL_IN, 1'b1, 1'b0);

    // Flush while in STALL returns to RUN
    step(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    exp3("stl_enter", '0, 1'b0, 1'b1);
    step(); idle(); flush = 1'b1; #1;
    exp3("stl_flush", '0, 1'b1, 1'b0);
    step(); idle(); #1;
    exp3("stl_flush_run", CTRL_IN, 1'b1, 1'b0);

    // Flush beats HALT
    step(); halt_in = 1'b1; flush = 1'b1; #1;
    exp3("flush_halt", '0, 1'b1, 1'b0);
    check("flush_halt_o", 32'(d3_halt), 0);
    step(); idle(); #1;
    check("flush_halt_nohalted", 32'(d3_halted), 0);

    // Enable=0 in STALL with cnt=2: state and cnt held
    reset_dut();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    exp3("en_haz", '0, 1'b0, 1'b1);
    step(); idle(); enable = 1'b0; #1;
    exp3("en0_a", '0, 1'b0, 1'b0);
    exp1("en0_a", '0, 1'b0, 1'b0);
    check("en0_halted", 32'(d3_halted), 0);
    step(); #1;
    exp3("en0_b", '0, 1'b0, 1'b0);
    step(); enable = 1'b1; #1;
    exp3("en1_a", '0, 1'b0, 1'b1);
    step(); #1;
    exp3("en1_b", '0, 1'b0, 1'b1);
    step(); #1;
    exp3("en1_c", CTRL_IN, 1'b1, 1'b0);
`ifdef ID_HAZARD_STALL_CNT_EN
    check("en_scnt", 32'(d3_scnt), 3);
`endif

    // HALT: one pulse, then frozen until reset
    reset_dut();
    halt_in = 1'b1; #1;
    check("halt_pulse", 32'(d3_halt), 1);
    check("halt_pulse_halted", 32'(d3_halted), 0);
    exp3("halt_pulse", '0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      flush = (c == 1); ex_memread = (c == 2); ex_rt = 5'd5; id_rs = 5'd5;
      #1;
      check($sformatf("halted_o_c%0d", c), 32'(d3_halt), 0);
      check($sformatf("halted_c%0d", c), 32'(d3_halted), 1);
      exp3($sformatf("halted_c%0d", c), '0, 1'b0, 1'b0);
    end
    step(); enable = 1'b0; #1;
    check("halted_en0", 32'(d3_halted), 1);
    rst_n = 1'b0; #1;
    check("halted_rst", 32'(d3_halted), 0);
    exp3("halted_rst", '0, 1'b0, 1'b0);
    step(); rst_n = 1'b1; idle(); #1;
    exp3("halt_after_rst", CTRL_IN, 1'b1, 1'b0);
    check("halt_after_rst_halted", 32'(d3_halted), 0);

    // Async reset mid-STALL aborts the stall
    step(); ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; #1;
    exp3("arst_haz", '0, 1'b0, 1'b1);
    step(); idle(); #1;
    exp3("arst_stl", '0, 1'b0, 1'b1);
    #1; rst_n = 1'b0; #1;
    exp3("arst_now", '0, 1'b0, 1'b0);
    step(); rst_n = 1'b1; #1;
    exp3("arst_run0", CTRL_IN, 1'b1, 1'b0);
    step(); #1;
    exp3("arst_run1", CTRL_IN, 1'b1, 1'b0);

    // Persistent hazard: re-evaluated after each stall window; counter saturation
    reset_dut();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      #1;
      check($sformatf("rehaz_d1_c%0d", c), 32'(d1_stall), 1);
      check($sformatf("rehaz_d3_c%0d", c), 32'(d3_stall), 1);
    end
    step(); idle(); #1;
`ifdef ID_HAZARD_STALL_CNT_EN
    check("sat_d1_scnt", 32'(d1_scnt), 3);
    check("sat_d3_scnt", 32'(d3_scnt), 5);
`endif
    exp1("rehaz_end", CTRL_IN, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
